// File: rtl/mem_pkg.sv
// Types and constants shared by the stream reader, its output FIFO and the dual-port RAM.
package mem_pkg;

    localparam int MEM_ADDR_WIDTH = 6;
    localparam int MEM_DATA_WIDTH = 14;
    localparam int FIFO_DEPTH     = 2;
    localparam int FIFO_CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry registered FIFO with a valid/ready output side; carries {last, data} words.
// Handshake: a beat transfers on a cycle with o_valid && i_ready; o_valid/o_data hold until then.
module stream_skid_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = MEM_DATA_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WIDTH-1:0]      o_data,
    output logic [FIFO_CNT_W-1:0] o_count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_rd;
    logic [PW-1:0]         r_wr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_pop;

    assign w_pop   = (r_count != '0) & i_ready;
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    // The writer never pushes into a full FIFO unless a pop frees a slot in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + {{(FIFO_CNT_W-1){1'b0}}, i_push}
                               - {{(FIFO_CNT_W-1){1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Walks an address range on one port of the synchronous-read RAM and streams each word out
// as a valid/ready beat, tagging the final word with out_last.
module mem_stream_reader
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output state_t                dbg_state,
    output logic [FIFO_CNT_W-1:0] dbg_fifo_count
);

    localparam logic [ADDR_WIDTH:0] ONE_WORD = 1;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic                    w_start;
    logic                    w_abort;
    logic                    w_pop;
    logic                    w_issue;
    logic [FIFO_CNT_W:0]     w_occupancy;
    logic [FIFO_CNT_W-1:0]   w_fifo_count;

    assign w_start = (r_state == IDLE) & start;
    assign w_abort = (r_state != IDLE) & abort;
    assign w_pop   = out_valid & out_ready;

    // Words already held plus the one coming back from the RAM, less the one leaving now.
    assign w_occupancy = {1'b0, w_fifo_count} + {{FIFO_CNT_W{1'b0}}, r_inflight}
                       - {{FIFO_CNT_W{1'b0}}, w_pop};
    assign w_issue     = (r_state == RUN) & ~w_abort & (w_occupancy < FIFO_CNT_W'(FIFO_DEPTH));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = (length != '0) ? RUN : DONE;
            RUN:     if (w_issue && r_remaining == ONE_WORD) w_state_next = DRAIN;
            DRAIN:   if (w_fifo_count == '0 && !r_inflight) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_abort) w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & (r_remaining == ONE_WORD);
            if (w_start) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    stream_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_abort),
        .i_push  (r_inflight & ~w_abort),
        .i_data  ({r_inflight_last, mem_data_out}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  ({out_last, out_data}),
        .o_count (w_fifo_count)
    );

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign mem_addr       = r_addr;
    assign mem_write_en   = 1'b0;
    assign mem_data_in    = '0;
    assign dbg_state      = r_state;
    assign dbg_fifo_count = w_fifo_count;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: a RAM model feeds the reader, and expected beats are queued at start.
module tb_mem_stream_reader;
    import mem_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 14;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_write_en;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    state_t        dbg_state;
    logic [1:0]    dbg_fifo_count;

    mem_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_write_en   (mem_write_en),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    // Clock / cycle counter / RAM model (registered read data)
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) ram_q <= ram[mem_addr];
    assign mem_data_out = ram_q;

    // Scoreboard state
    logic [DW:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int beats = 0;
    int last_pop_edge = 0;
    int ready_mode = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_beat = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: a transfer is simply len words read from consecutive addresses mod depth.
    task automatic push_expected(input int base, input int len);
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, ram[(base + i) % DEPTH]});
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_beat", {17'b0, out_last, out_data}, {17'b0, prev_beat});
            end
            total++;
            if (dbg_fifo_count > 2'd2) begin
                bad++;
                $display("FAIL fifo_count_max: got %0d want <=2", dbg_fifo_count);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", {out_last, out_data});
                end else begin
                    check("beat", {17'b0, out_last, out_data}, {17'b0, exp_q.pop_front()});
                end
                beats         <= beats + 1;
                last_pop_edge <= cyc + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            prev_stall <= out_valid && !out_ready && !abort;
            prev_beat  <= {out_last, out_data};
        end
    end

    // Ready driver: 0 = always, 1 = pattern 1,0,0,1, 2 = random, 3 = never
    initial begin
        int k;
        k = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            k++;
        end
    end

    // Driver tasks; all called aligned to 1 time unit after a rising edge
    task automatic issue_start(input int base, input int len, output int start_edge);
        start     = 1'b1;
        base_addr = base[AW-1:0];
        length    = len[AW:0];
        push_expected(base, len);
        @(posedge clk);
        #1;
        start_edge = cyc;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done within %0d cycles", budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_last"}, {31'b0, out_last}, 32'd0);
        check({tag, "_data"}, {18'b0, out_data}, 32'd0);
        check({tag, "_addr"}, {26'b0, mem_addr}, 32'd0);
        check({tag, "_state"}, {30'b0, dbg_state}, {30'b0, IDLE});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, d, n, d0, b0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base_addr = '0;
        length = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(32'h100 + i);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("wr_en", {31'b0, mem_write_en}, 32'd0);
        check("wr_data", {18'b0, mem_data_in}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic transfer: first valid on the third edge counting the start-sampling edge.
        issue_start(0, 4, s);
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first_valid_edge", n, 3);
        wait_done(50, d);
        check("len4_done_cycle", d - s, 7);
        check("done_after_last_pop", d, last_pop_edge + 1);
        check("len4_drained", exp_q.size(), 0);

        // Address wrap
        issue_start(62, 4, s);
        wait_done(50, d);
        check("wrap_done_cycle", d - s, 7);
        check("wrap_drained", exp_q.size(), 0);

        // Zero length: done right after the start edge, no beats
        b0 = beats;
        issue_start(9, 0, s);
        check("len0_done", {31'b0, done}, 32'd1);
        check("len0_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("len0_done_gone", {31'b0, done}, 32'd0);
        check("len0_idle", {31'b0, busy}, 32'd0);
        check("len0_no_beats", beats - b0, 0);

        // Backpressure pattern
        ready_mode = 1;
        b0 = beats;
        issue_start(20, 8, s);
        wait_done(100, d);
        check("stall_beats", beats - b0, 8);
        check("stall_drained", exp_q.size(), 0);
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Full pass, start ignored during DONE, then an immediate second pass
        issue_start(0, 64, s);
        d = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                d = cyc;
                break;
            end
        end
        check("full_done_cycle", d - s, 67);
        start = 1'b1;
        base_addr = 6'd5;
        length = 7'd3;
        @(posedge clk);
        #1;
        base_addr = '0;
        length = 7'd64;
        push_expected(0, 64);
        @(posedge clk);
        #1;
        start = 1'b0;
        s2 = cyc;
        wait_done(200, d);
        check("second_pass_cycle", d - s2, 67);
        check("second_pass_drained", exp_q.size(), 0);

        // Abort with a full FIFO and stalled output
        ready_mode = 3;
        @(posedge clk);
        #1;
        issue_start(10, 20, s);
        n = 0;
        while (dbg_fifo_count != 2'd2 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_fifo_full", {30'b0, dbg_fifo_count}, 32'd2);
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        ready_mode = 0;
        issue_start(40, 5, s);
        wait_done(60, d);
        check("after_abort_drained", exp_q.size(), 0);

        // Abort while idle does nothing; start beats abort in IDLE
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("idle_abort_busy", {31'b0, busy}, 32'd0);
        start = 1'b1;
        base_addr = 6'd3;
        length = 7'd2;
        push_expected(3, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_wins_busy", {31'b0, busy}, 32'd1);
        wait_done(40, d);
        check("start_wins_drained", exp_q.size(), 0);

        // Randomised transfers with random RAM contents and random backpressure
        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
            issue_start($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), s);
            wait_done(1000, d);
            check("rand_drained", exp_q.size(), 0);
        end
        ready_mode = 0;

        // Asynchronous reset in the middle of a run
        issue_start(0, 30, s);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue_start(7, 3, s);
        wait_done(40, d);
        check("post_reset_drained", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
